kan_weighted_accumulator: RTL and testbench



---
 rtl/kan_weighted_accumulator.sv | 175 +++++++++++++++++
 tb/tb_kan_weighted_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kan_weighted_accumulator.sv
// Weighted-sum half of a KAN neuron: joins basis and weight lanes, multiplies lane-wise,
// sums across channels and accumulates per tlast packet, emitting one rounded, saturated result.
module kan_weighted_accumulator #(
  parameter int DATA_WIDTH_BASIS       = 16,
  parameter int FRACTIONAL_BITS_BASIS  = 16,
  parameter int USE_UNSIGNED_BASIS     = 1,
  parameter int DATA_WIDTH_WEIGHT      = 16,
  parameter int FRACTIONAL_BITS_WEIGHT = 12,
  parameter int DATA_WIDTH_ACC         = 40,
  parameter int DATA_WIDTH_RSLT        = 16,
  parameter int FRACTIONAL_BITS_RSLT   = 12,
  parameter int CHANNELS               = 5,
  parameter int KEEP_ENABLE            = (DATA_WIDTH_RSLT > 8),
  parameter int KEEP_WIDTH             = (DATA_WIDTH_RSLT + 7) / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNELS*DATA_WIDTH_BASIS-1:0]  s_axis_basis_tdata,
  input  logic [CHANNELS-1:0]                   s_axis_basis_tvalid,
  output logic [CHANNELS-1:0]                   s_axis_basis_tready,
  input  logic [CHANNELS-1:0]                   s_axis_basis_tlast,
  input  logic [CHANNELS*DATA_WIDTH_WEIGHT-1:0] s_axis_weight_tdata,
  input  logic                                  s_axis_weight_tvalid,
  output logic                                  s_axis_weight_tready,
  input  logic                                  s_axis_weight_tlast,
  output logic [DATA_WIDTH_RSLT-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  err_tlast_mismatch
);

  localparam int BW      = DATA_WIDTH_BASIS;
  localparam int WW      = DATA_WIDTH_WEIGHT;
  localparam int PW      = BW + 1 + WW;
  localparam int SW      = PW + $clog2(CHANNELS);
  localparam int ACC     = DATA_WIDTH_ACC;
  localparam int RW      = DATA_WIDTH_RSLT;
  localparam int SHIFT   = FRACTIONAL_BITS_BASIS + FRACTIONAL_BITS_WEIGHT - FRACTIONAL_BITS_RSLT;
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC:0] RND_ADD = (SHIFT > 0) ? ((ACC + 1)'(1'b1) << RND_POS) : '0;
  localparam logic signed [ACC:0] SAT_MAX = {{(ACC + 2 - RW){1'b0}}, {(RW - 1){1'b1}}};
  localparam logic signed [ACC:0] SAT_MIN = {{(ACC + 2 - RW){1'b1}}, {(RW - 1){1'b0}}};

  logic                          w_ce;
  logic                          w_accept;
  logic                          w_mismatch;
  logic signed [BW:0]            w_bext [CHANNELS];
  logic signed [WW-1:0]          w_wt   [CHANNELS];
  logic signed [PW-1:0]          w_prod [CHANNELS];
  logic signed [SW-1:0]          w_sum;
  logic signed [ACC-1:0]         w_s_ext;
  logic signed [ACC:0]           w_rnd;
  logic signed [ACC:0]           w_shift;
  logic [RW-1:0]                 w_sat;

  logic                          r_in_valid, r_in_last;
  logic [CHANNELS*BW-1:0]        r_in_basis;
  logic [CHANNELS*WW-1:0]        r_in_weight;
  logic                          r_p_valid, r_p_last;
  logic signed [PW-1:0]          r_p_prod [CHANNELS];
  logic                          r_s_valid, r_s_last;
  logic signed [SW-1:0]          r_s_sum;
  logic                          r_a_valid, r_a_last, r_a_first;
  logic signed [ACC-1:0]         r_acc;
  logic                          r_out_valid;
  logic [RW-1:0]                 r_out_data;
  logic                          r_err;

  // Global stall: the whole pipeline moves only when the output slot can take a result.
  assign w_ce       = !r_out_valid || m_axis_tready;
  assign w_accept   = (&s_axis_basis_tvalid) && s_axis_weight_tvalid && w_ce;
  assign w_mismatch = (s_axis_basis_tlast != {CHANNELS{s_axis_basis_tlast[0]}}) ||
                      (s_axis_weight_tlast != s_axis_basis_tlast[0]);

  assign s_axis_basis_tready  = {CHANNELS{w_ce}};
  assign s_axis_weight_tready = w_ce;
  assign m_axis_tdata         = r_out_data;
  assign m_axis_tvalid        = r_out_valid;
  assign m_axis_tlast         = 1'b1;
  assign err_tlast_mismatch   = r_err;
  // With keep disabled downstream assumes all bytes valid, so the bus is all ones either way.
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? {KEEP_WIDTH{1'b1}} : {KEEP_WIDTH{1'b1}};

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (USE_UNSIGNED_BASIS != 0) begin
        w_bext[i] = {1'b0, r_in_basis[i*BW +: BW]};
      end else begin
        w_bext[i] = {r_in_basis[i*BW+BW-1], r_in_basis[i*BW +: BW]};
      end
      w_wt[i]   = r_in_weight[i*WW +: WW];
      w_prod[i] = PW'(w_bext[i]) * PW'(w_wt[i]);
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sum = w_sum + SW'(r_p_prod[i]);
    end
  end

  always_comb begin
    w_s_ext = {{(ACC - SW){r_s_sum[SW-1]}}, r_s_sum};
    w_rnd   = {r_acc[ACC-1], r_acc} + RND_ADD;
    w_shift = w_rnd >>> SHIFT;
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[RW-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[RW-1:0];
    end else begin
      w_sat = w_shift[RW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid  <= 1'b0;
      r_in_last   <= 1'b0;
      r_in_basis  <= '0;
      r_in_weight <= '0;
      r_p_valid   <= 1'b0;
      r_p_last    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_p_prod[i] <= '0;
      end
      r_s_valid   <= 1'b0;
      r_s_last    <= 1'b0;
      r_s_sum     <= '0;
      r_a_valid   <= 1'b0;
      r_a_last    <= 1'b0;
      r_a_first   <= 1'b1;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_accept && w_mismatch;
      if (w_ce) begin
        r_in_valid <= w_accept;
        if (w_accept) begin
          r_in_basis  <= s_axis_basis_tdata;
          r_in_weight <= s_axis_weight_tdata;
          r_in_last   <= s_axis_basis_tlast[0];
        end
        r_p_valid <= r_in_valid;
        if (r_in_valid) begin
          r_p_prod <= w_prod;
          r_p_last <= r_in_last;
        end
        r_s_valid <= r_p_valid;
        if (r_p_valid) begin
          r_s_sum  <= w_sum;
          r_s_last <= r_p_last;
        end
        // A beat following a packet end (or reset) starts a fresh sum.
        r_a_valid <= r_s_valid;
        if (r_s_valid) begin
          r_acc     <= r_a_first ? w_s_ext : r_acc + w_s_ext;
          r_a_last  <= r_s_last;
          r_a_first <= r_s_last;
        end
        if (r_a_valid && r_a_last) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_sat;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kan_weighted_accumulator.sv
// Scoreboard bench for kan_weighted_accumulator: directed packets push expected results,
// a monitor pops and compares on every output handshake.
module tb_kan_weighted_accumulator;

  localparam int CH = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*16-1:0]  s_axis_basis_tdata;
  logic [CH-1:0]     s_axis_basis_tvalid;
  logic [CH-1:0]     s_axis_basis_tready;
  logic [CH-1:0]     s_axis_basis_tlast;
  logic [CH*16-1:0]  s_axis_weight_tdata;
  logic              s_axis_weight_tvalid;
  logic              s_axis_weight_tready;
  logic              s_axis_weight_tlast;
  logic [15:0]       m_axis_tdata;
  logic [1:0]        m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              err_tlast_mismatch;

  kan_weighted_accumulator dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_basis_tdata   (s_axis_basis_tdata),
    .s_axis_basis_tvalid  (s_axis_basis_tvalid),
    .s_axis_basis_tready  (s_axis_basis_tready),
    .s_axis_basis_tlast   (s_axis_basis_tlast),
    .s_axis_weight_tdata  (s_axis_weight_tdata),
    .s_axis_weight_tvalid (s_axis_weight_tvalid),
    .s_axis_weight_tready (s_axis_weight_tready),
    .s_axis_weight_tlast  (s_axis_weight_tlast),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tkeep         (m_axis_tkeep),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
    .m_axis_tlast         (m_axis_tlast),
    .err_tlast_mismatch   (err_tlast_mismatch)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          err_pulses = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [CH*16-1:0] all_lanes(input logic [15:0] v);
    return {CH{v}};
  endfunction

  function automatic logic [CH*16-1:0] lane0(input logic [15:0] v);
    return {64'd0, v};
  endfunction

  // Monitor: handshake happens at the posedge following this negedge (tready only moves after posedge).
  always @(negedge clk) begin
    if (!rst) begin
      if (err_tlast_mismatch) err_pulses++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", m_axis_tdata);
        end else begin
          chk("result", {48'd0, m_axis_tdata}, {48'd0, exp_q.pop_front()});
          chk("tlast", {63'd0, m_axis_tlast}, 64'd1);
          chk("tkeep", {62'd0, m_axis_tkeep}, 64'd3);
        end
      end
    end
  end

  task automatic send_beat(input logic [CH*16-1:0] b, input logic [CH*16-1:0] w,
                           input logic bl, input logic wl);
    int waitc;
    s_axis_basis_tdata   = b;
    s_axis_weight_tdata  = w;
    s_axis_basis_tvalid  = '1;
    s_axis_weight_tvalid = 1'b1;
    s_axis_basis_tlast   = {CH{bl}};
    s_axis_weight_tlast  = wl;
    waitc = 0;
    forever begin
      @(negedge clk);
      if (s_axis_basis_tready == 5'h1f && s_axis_weight_tready) break;
      stalls++;
      waitc++;
      if (waitc > 200) begin
        $display("FAIL accept_timeout: got no ready expected ready within 200 cycles");
        $fatal(1, "input handshake timed out");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input int n, input logic [CH*16-1:0] b, input logic [CH*16-1:0] w,
                             input logic [15:0] expv);
    exp_q.push_back(expv);
    for (int i = 0; i < n; i++) begin
      send_beat(b, w, (i == n - 1), (i == n - 1));
    end
  endtask

  task automatic idle();
    s_axis_basis_tvalid  = '0;
    s_axis_weight_tvalid = 1'b0;
    s_axis_basis_tlast   = '0;
    s_axis_weight_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int n;
    rst = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_basis_tdata  = '0;
    s_axis_weight_tdata = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata", {48'd0, m_axis_tdata}, 64'd0);
    chk("rst_err", {63'd0, err_tlast_mismatch}, 64'd0);
    chk("rst_basis_ready", {59'd0, s_axis_basis_tready}, 64'h1f);
    chk("rst_weight_ready", {63'd0, s_axis_weight_tready}, 64'd1);
    @(posedge clk);
    #1;

    // Single beat: 0.5 * 2.0 = 1.0, with latency measured from the accepting edge.
    send_packet(1, lane0(16'h8000), lane0(16'h2000), 16'h1000);
    c0 = cyc;
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_axis_tvalid && n < 20);
    chk("latency", 64'(cyc - c0), 64'd4);
    drain();

    err_pulses = 0;
    send_packet(5, all_lanes(16'h8000), all_lanes(16'h1000), 16'h7FFF);
    idle();
    drain();
    send_packet(4, all_lanes(16'h4000), all_lanes(16'hF000), 16'hB000);
    send_packet(1, lane0(16'h0001), lane0(16'h0001), 16'h0000);
    idle();
    drain();
    chk("no_spurious_err", 64'(err_pulses), 64'd0);

    // Back-to-back packets with the sink always ready must never stall the inputs.
    stalls = 0;
    send_packet(1, lane0(16'h8000), lane0(16'h2000), 16'h1000);
    send_packet(4, all_lanes(16'h4000), all_lanes(16'hF000), 16'hB000);
    idle();
    chk("b2b_stalls", 64'(stalls), 64'd0);
    drain();

    // Backpressure: hold the sink for 10 cycles while the next packet is queued behind.
    m_axis_tready = 1'b0;
    fork
      begin
        send_packet(1, lane0(16'h8000), lane0(16'h2000), 16'h1000);
        send_packet(4, all_lanes(16'h4000), all_lanes(16'hF000), 16'hB000);
        idle();
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_axis_tvalid && n < 50);
        for (int k = 0; k < 10; k++) begin
          chk("bp_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
          chk("bp_tdata", {48'd0, m_axis_tdata}, 64'h1000);
          chk("bp_basis_ready", {59'd0, s_axis_basis_tready}, 64'd0);
          chk("bp_weight_ready", {63'd0, s_axis_weight_tready}, 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    drain();

    // Weight tlast disagrees on the last beat: one error pulse, result still produced.
    err_pulses = 0;
    exp_q.push_back(16'h1000);
    send_beat(lane0(16'h8000), lane0(16'h2000), 1'b1, 1'b0);
    idle();
    drain();
    chk("err_pulses", 64'(err_pulses), 64'd1);

    // Reset after two beats of a five-beat packet discards the partial sum.
    send_beat(all_lanes(16'h8000), all_lanes(16'h1000), 1'b0, 1'b0);
    send_beat(all_lanes(16'h8000), all_lanes(16'h1000), 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send_packet(1, lane0(16'h8000), lane0(16'h2000), 16'h1000);
    idle();
    drain();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
